// File: rtl/clock_time_counter.sv
// Wall clock: seconds prescaler, BCD hh:mm time of day,
// manual minute/hour set pulses and a blinking alarm.
module clock_time_counter #(
  parameter int CLK_DIV    = 50000000,
  parameter int ALARM_HOUR = 7,
  parameter int ALARM_MIN  = 0,
  parameter int ALARM_LEN  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [3:0] min_units,
  output logic [3:0] min_tens,
  output logic [3:0] hour_units,
  output logic [3:0] hour_tens,
  output logic       sec_tick,
  output logic [6:0] alarm_signal
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] P_MAX = PW'(CLK_DIV - 1);
  localparam logic [7:0] A_HR =
    {4'(ALARM_HOUR / 10), 4'(ALARM_HOUR % 10)};
  localparam logic [7:0] A_MIN =
    {4'(ALARM_MIN / 10), 4'(ALARM_MIN % 10)};

  typedef enum logic {IDLE, RING} state_t;

  // {carry, tens, units}
  function automatic logic [8:0] min_step(input logic [7:0] m);
    logic [8:0] r;
    r = {1'b0, m};
    if (m[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      if (m[7:4] == 4'd5) begin
        r[7:4] = 4'd0;
        r[8]   = 1'b1;
      end else begin
        r[7:4] = m[7:4] + 4'd1;
      end
    end else begin
      r[3:0] = m[3:0] + 4'd1;
    end
    return r;
  endfunction

  function automatic logic [7:0] hr_step(input logic [7:0] h);
    logic [7:0] r;
    r = h;
    if (h == 8'h23) begin
      r = 8'h00;
    end else if (h[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = h[7:4] + 4'd1;
    end else begin
      r[3:0] = h[3:0] + 4'd1;
    end
    return r;
  endfunction

  logic [PW-1:0] presc, presc_n;
  logic [5:0]    sec, sec_n;
  logic [7:0]    min_q, min_n;
  logic [7:0]    hr_q, hr_n;
  logic [8:0]    min_inc;
  logic [7:0]    hr_inc;
  logic          tick, inc_any, hit;
  state_t        state, state_n;
  logic [7:0]    remain, remain_n;
  logic          blink, blink_n;
  logic [6:0]    alarm_n;

  always_comb begin
    tick    = (presc == P_MAX);
    inc_any = inc_min | inc_hour;
    presc_n = tick ? '0 : presc + PW'(1);
    min_inc = min_step(min_q);
    hr_inc  = hr_step(hr_q);
    sec_n   = sec;
    min_n   = min_q;
    hr_n    = hr_q;
    // manual set wins over the tick; minute set never carries
    if (inc_any) begin
      if (inc_min) begin
        sec_n = 6'd0;
        min_n = min_inc[7:0];
      end
      if (inc_hour) hr_n = hr_inc;
    end else if (tick) begin
      if (sec == 6'd59) begin
        sec_n = 6'd0;
        min_n = min_inc[7:0];
        if (min_inc[8]) hr_n = hr_inc;
      end else begin
        sec_n = sec + 6'd1;
      end
    end
    hit = tick & ~inc_any & (sec_n == 6'd0)
        & (min_n == A_MIN) & (hr_n == A_HR);
  end

  always_comb begin
    state_n  = state;
    remain_n = remain;
    blink_n  = blink;
    unique case (state)
      IDLE: begin
        if (hit) begin
          state_n  = RING;
          remain_n = 8'(ALARM_LEN);
          blink_n  = 1'b0;
        end
      end
      RING: begin
        if (inc_any) begin
          state_n = IDLE;
          blink_n = 1'b0;
        end else if (tick) begin
          remain_n = remain - 8'd1;
          blink_n  = ~blink;
          if (remain == 8'd1) begin
            state_n = IDLE;
            blink_n = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    alarm_n = (state_n == RING && !blink_n) ? 7'h7F : 7'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc        <= '0;
      sec          <= '0;
      min_q        <= '0;
      hr_q         <= '0;
      sec_tick     <= 1'b0;
      state        <= IDLE;
      remain       <= '0;
      blink        <= 1'b0;
      alarm_signal <= '0;
    end else begin
      presc        <= presc_n;
      sec          <= sec_n;
      min_q        <= min_n;
      hr_q         <= hr_n;
      sec_tick     <= tick;
      state        <= state_n;
      remain       <= remain_n;
      blink        <= blink_n;
      alarm_signal <= alarm_n;
    end
  end

  assign min_units  = min_q[3:0];
  assign min_tens   = min_q[7:4];
  assign hour_units = hr_q[3:0];
  assign hour_tens  = hr_q[7:4];

endmodule

// File: doc/clock_time_counter.md
CLOCK_TIME_COUNTER -- requirements
Module: clock_time_counter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000000, clk cycles per second tick (legal range 2..2^26).
REQ-002 SHALL have parameter ALARM_HOUR, default 7, alarm hour (0..23, binary).
REQ-003 SHALL have parameter ALARM_MIN, default 0, alarm minute (0..59, binary).
REQ-004 SHALL have parameter ALARM_LEN, default 10, alarm duration in second ticks (1..255).
REQ-005 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port inc_min  input  1  one-cycle pulse, advance minutes by one.
REQ-008 SHALL have port inc_hour  input  1  one-cycle pulse, advance hours by one.
REQ-009 SHALL have port min_units  output  4  BCD minute units, 0..9.
REQ-010 SHALL have port min_tens  output  4  BCD minute tens, 0..5.
REQ-011 SHALL have port hour_units  output  4  BCD hour units, 0..9.
REQ-012 SHALL have port hour_tens  output  4  BCD hour tens, 0..2.
REQ-013 SHALL have port sec_tick  output  1  registered one-cycle pulse per second tick.
REQ-014 SHALL have port alarm_signal  output  7  LED pattern, 7'h7F or 7'h00.

Function
REQ-015 Prescaler SHALL count 0..CLK_DIV-1 and wrap to 0; tick is internal and true when prescaler == CLK_DIV-1.
REQ-016 sec_tick SHALL be high exactly the cycle after each tick (1-cycle registered latency).
REQ-017 Time state SHALL be seconds (0..59), minutes BCD (00..59), hours BCD (00..23); all outputs SHALL be registers, no combinational path from inputs.
REQ-018 On tick with no inc pulse: seconds+1; 59->0 carries minute; minute units 9->0 carries tens; 59->00 carries hour; hours 23->00; hour units wrap 9->0 with tens+1 except 23->00.
REQ-019 Time outputs SHALL reflect a tick update on the cycle after the tick (same cycle as sec_tick).
REQ-020 inc_min SHALL advance minutes by one modulo 60 with no carry into hours; seconds SHALL be cleared to 0.
REQ-021 inc_hour SHALL advance hours by one modulo 24; minutes and seconds unchanged.
REQ-022 inc_min and inc_hour together in one cycle SHALL apply both (minute per REQ-020, hour per REQ-021).
REQ-023 Any inc pulse coincident with tick SHALL suppress the tick's time advance; prescaler still wraps and sec_tick still pulses.
REQ-024 Alarm FSM states: IDLE, RING. IDLE->RING when a tick (not an inc) produces time ALARM_HOUR:ALARM_MIN:00; remaining count loaded with ALARM_LEN.
REQ-025 In RING each subsequent tick SHALL decrement remaining and toggle a blink flag; RING->IDLE on the tick where remaining reaches 0.
REQ-026 alarm_signal SHALL be 7'h7F while RING and blink flag clear, 7'h00 while blink set or IDLE; entry to RING clears blink flag.
REQ-027 Any inc pulse while RING SHALL return FSM to IDLE (snooze/cancel) on the next cycle.
REQ-028 Setting time via inc to the alarm time SHALL NOT start the alarm.

Reset
REQ-029 rst sampled high SHALL force prescaler 0, time 00:00:00, all BCD outputs 0, sec_tick 0, FSM IDLE, alarm_signal 7'h00, blink 0.
REQ-030 rst SHALL take priority over tick and inc pulses in the same cycle; reset mid-RING SHALL abort the alarm.
REQ-031 After rst deasserts, first tick SHALL occur on the CLK_DIV-th clk edge, sec_tick one cycle later.

Verification (CLK_DIV=4, ALARM_HOUR=0, ALARM_MIN=2, ALARM_LEN=3)
REQ-032 Reset then 4 cycles -> sec_tick high on cycle 5 only; all digits 0; sec_tick period exactly 4 cycles thereafter.
REQ-033 Run 120 ticks from reset -> min_tens=0, min_units=2, alarm_signal 7'h7F; next tick 7'h00, next 7'h7F, next 7'h00 and IDLE.
REQ-034 From reset, 23 inc_hour pulses then 59 inc_min pulses, then 60 ticks -> 00:00 with hour rollover; no alarm fires on the inc path.
REQ-035 inc_min asserted on a tick cycle at seconds=59 -> minutes+1 only once, seconds=0, sec_tick still pulses.
REQ-036 rst asserted during RING -> next cycle alarm_signal 7'h00, time 00:00:00; inc_min during RING -> alarm_signal 7'h00 next cycle.
